// File: rtl/phoeniX_lsu_pkg.sv
// Shared definitions for the load/store unit: opcodes, access sizes, FSM states
// and the legality check applied to every incoming memory access.
package phoeniX_lsu_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   // Unsigned sizes exist only for loads; halfwords and words must be naturally aligned.
   function automatic logic access_ok(input logic [2:0] f3, input logic is_store,
                                      input logic [1:0] offset);
      logic ok;
      case (f3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~offset[0];
         F3_W:    ok = (offset == 2'b00);
         F3_BU:   ok = ~is_store;
         F3_HU:   ok = ~is_store & ~offset[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_data_aligner.sv
// Combinational lane steering: store data replication and byte strobes on the way
// out, byte-lane shift and sign/zero extension of read data on the way back.
module lsu_data_aligner
   import phoeniX_lsu_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_offset,
   input  logic [31:0] st_data,
   output logic [3:0]  st_wstrb,
   output logic [31:0] st_wdata,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_offset,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   always_comb begin
      st_wstrb = 4'b1111;
      st_wdata = st_data;
      case (st_funct3)
         F3_B: begin
            st_wstrb = 4'b0001 << st_offset;
            st_wdata = {4{st_data[7:0]}};
         end
         F3_H: begin
            st_wstrb = 4'b0011 << st_offset;
            st_wdata = {2{st_data[15:0]}};
         end
         default: begin
            st_wstrb = 4'b1111;
            st_wdata = st_data;
         end
      endcase
   end

   assign shifted = ld_rdata >> {ld_offset, 3'b000};

   always_comb begin
      ld_data = shifted;
      case (ld_funct3)
         F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   ld_data = {24'd0, shifted[7:0]};
         F3_HU:   ld_data = {16'd0, shifted[15:0]};
         default: ld_data = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_controller.sv
// Single-outstanding load/store sequencer: validates the access, holds the request
// stable until memory responds or the timeout expires, then pulses completion.
module load_store_controller
   import phoeniX_lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [31:0] address,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        store_done,
   output logic        misaligned,
   output logic        bus_error,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

   lsu_state_t  state_reg;
   logic [29:0] word_addr_reg;
   logic [1:0]  offset_reg;
   logic [2:0]  funct3_reg;
   logic        we_reg;
   logic [3:0]  wstrb_reg;
   logic [31:0] wdata_reg;
   logic [7:0]  count_reg;
   logic [31:0] load_data_reg;
   logic        load_valid_reg;
   logic        store_done_reg;
   logic        misaligned_reg;
   logic        bus_error_reg;

   logic        is_mem;
   logic        is_store;
   logic        legal;
   logic        accept;
   logic        reject;
   logic [3:0]  st_wstrb;
   logic [31:0] st_wdata;
   logic [31:0] ld_data;

   assign is_mem   = start & ((opcode == OPC_LOAD) | (opcode == OPC_STORE));
   assign is_store = (opcode == OPC_STORE);
   assign legal    = access_ok(funct3, is_store, address[1:0]);
   assign accept   = (state_reg == IDLE) & is_mem & legal;
   assign reject   = (state_reg == IDLE) & is_mem & ~legal;

   lsu_data_aligner u_aligner (
      .st_funct3 (funct3),
      .st_offset (address[1:0]),
      .st_data   (store_data),
      .st_wstrb  (st_wstrb),
      .st_wdata  (st_wdata),
      .ld_funct3 (funct3_reg),
      .ld_offset (offset_reg),
      .ld_rdata  (mem_rdata),
      .ld_data   (ld_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         word_addr_reg  <= '0;
         offset_reg     <= '0;
         funct3_reg     <= '0;
         we_reg         <= 1'b0;
         wstrb_reg      <= '0;
         wdata_reg      <= '0;
         count_reg      <= '0;
         load_data_reg  <= '0;
         load_valid_reg <= 1'b0;
         store_done_reg <= 1'b0;
         misaligned_reg <= 1'b0;
         bus_error_reg  <= 1'b0;
      end else begin
         load_valid_reg <= 1'b0;
         store_done_reg <= 1'b0;
         misaligned_reg <= 1'b0;
         bus_error_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  word_addr_reg <= address[31:2];
                  offset_reg    <= address[1:0];
                  funct3_reg    <= funct3;
                  we_reg        <= is_store;
                  wstrb_reg     <= is_store ? st_wstrb : 4'b0000;
                  wdata_reg     <= st_wdata;
                  count_reg     <= '0;
                  state_reg     <= REQ;
               end else if (reject) begin
                  misaligned_reg <= 1'b1;
               end
            end
            REQ: begin
               // A response in the limit cycle still completes the access.
               if (mem_ready) begin
                  if (!we_reg) begin
                     load_data_reg  <= ld_data;
                     load_valid_reg <= 1'b1;
                  end else begin
                     store_done_reg <= 1'b1;
                  end
                  state_reg <= DONE;
               end else if (count_reg == LIMIT) begin
                  bus_error_reg <= 1'b1;
                  state_reg     <= IDLE;
               end else begin
                  count_reg <= count_reg + 8'd1;
               end
            end
            DONE:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign stall      = accept | (state_reg == REQ);
   assign mem_req    = (state_reg == REQ);
   assign mem_we     = we_reg & mem_req;
   assign mem_addr   = {word_addr_reg, 2'b00};
   assign mem_wstrb  = wstrb_reg;
   assign mem_wdata  = wdata_reg;
   assign load_data  = load_data_reg;
   assign load_valid = load_valid_reg;
   assign store_done = store_done_reg;
   assign misaligned = misaligned_reg;
   assign bus_error  = bus_error_reg;

endmodule
